// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared constants, state encoding and inst-word field positions
// for the core_ctrl sequencer and its accumulation address generator.
package core_ctrl_pkg;

  // Array / feature-map geometry
  localparam int ROW      = 8;
  localparam int COL      = 8;
  localparam int LEN_KIJ  = 9;
  localparam int KI_DIM   = 3;
  localparam int NI_DIM   = 6;
  localparam int LEN_NIJ  = 36;
  localparam int LEN_ONIJ = 16;
  localparam int ACC_CYC  = LEN_KIJ + 3;
  localparam int ADDR_W   = 11;

  localparam logic [ADDR_W-1:0] WBASE = 11'd1024;

  // Sequencer states (explicit encodings kept stable for legacy dumps)
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CRST  = 4'd1,
    W2L0  = 4'd2,
    WLOAD = 4'd3,
    WGAP  = 4'd4,
    X2L0  = 4'd5,
    EXEC  = 4'd6,
    DRAIN = 4'd7,
    PWR   = 4'd8,
    ACC   = 4'd9,
    DONE  = 4'd10
  } state_t;

  // inst bit positions
  localparam int ACC_B      = 33;
  localparam int CEN_PMEM   = 32;
  localparam int WEN_PMEM   = 31;
  localparam int A_PMEM_LSB = 20;
  localparam int CEN_XMEM   = 19;
  localparam int WEN_XMEM   = 18;
  localparam int A_XMEM_LSB = 7;
  localparam int OFIFO_RD   = 6;
  localparam int IFIFO_WR   = 5;
  localparam int IFIFO_RD   = 4;
  localparam int L0_RD      = 3;
  localparam int L0_WR      = 2;
  localparam int EXECUTE    = 1;
  localparam int LOAD       = 0;

  // Both memories disabled, addresses 0, no strobes
  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  // Final cycle index of each fixed-length state
  function automatic logic [5:0] state_last(input state_t s);
    case (s)
      CRST:        return 6'd1;
      W2L0, WLOAD: return 6'(COL - 1);
      WGAP, DRAIN: return 6'(ROW + COL - 1);
      X2L0, EXEC:  return 6'(LEN_NIJ - 1);
      PWR:         return 6'(LEN_NIJ);
      ACC:         return 6'(ACC_CYC - 1);
      default:     return 6'd0;
    endcase
  endfunction

  // Fixed ordering of the per-kij phases before PWR
  function automatic state_t phase_next(input state_t s);
    case (s)
      CRST:    return W2L0;
      W2L0:    return WLOAD;
      WLOAD:   return WGAP;
      WGAP:    return X2L0;
      X2L0:    return EXEC;
      EXEC:    return DRAIN;
      DRAIN:   return PWR;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/core_ctrl_addr_gen.sv
// core_ctrl_addr_gen: psum address generator for the accumulation pass.
// Nested wrap counters k_c -> k_r -> o_c -> o_r; each advance steps to the next
// kernel position, wrapping into the next output pixel after the last one.
module core_ctrl_addr_gen
  import core_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);

  logic [1:0] k_r, k_c, o_r, o_c;

  // Counter chain, cleared outside the accumulation pass
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      k_r <= '0;
      k_c <= '0;
      o_r <= '0;
      o_c <= '0;
    end else if (advance) begin
      if (k_c == 2'(KI_DIM - 1)) begin
        k_c <= '0;
        if (k_r == 2'(KI_DIM - 1)) begin
          k_r <= '0;
          if (o_c == 2'(NI_DIM - KI_DIM)) begin
            o_c <= '0;
            o_r <= o_r + 2'd1;
          end else begin
            o_c <= o_c + 2'd1;
          end
        end else begin
          k_r <= k_r + 2'd1;
        end
      end else begin
        k_c <= k_c + 2'd1;
      end
    end
  end

  // k*LEN_NIJ split over k_r/k_c and merged with the pixel offset terms:
  // k_r weighs KI_DIM*LEN_NIJ + NI_DIM, k_c weighs LEN_NIJ + 1
  assign addr = 11'(k_r) * 11'(KI_DIM * LEN_NIJ + NI_DIM)
              + 11'(k_c) * 11'(LEN_NIJ + 1)
              + 11'(o_r) * 11'(NI_DIM)
              + 11'(o_c);

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: inst-word sequencer for core (weight/activation load, execute,
// drain, psum writeback per kij, then the SFP accumulation pass).
// Optional macro CORE_CTRL_OFIFO_HS_EN: PWR reads the OFIFO only when
// ofifo_valid is seen, instead of a fixed-count burst.
module core_ctrl
  import core_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  output logic [3:0]  kij_idx
);

  state_t      st, st_n;
  logic [5:0]  cnt, cnt_n;
  logic [3:0]  kij, kij_n, ocnt, ocnt_n;
  logic [33:0] inst_n;
  logic        crst_n, ov_n;
  logic        pwr_rd_n, pwr_wr_n, pwr_end;
  logic [5:0]  pwr_widx_n;
  logic        ag_adv, ag_clr;
  logic [ADDR_W-1:0] ag_addr;

  core_ctrl_addr_gen u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (ag_clr),
    .advance (ag_adv),
    .addr    (ag_addr)
  );

`ifdef CORE_CTRL_OFIFO_HS_EN
  // In handshake mode cnt counts issued reads; the cycle after the last read
  // carries the last write and closes PWR.
  assign pwr_end = (cnt == 6'(LEN_NIJ)) && !inst[OFIFO_RD];
`else
  logic unused_ofifo_valid;
  assign unused_ofifo_valid = ofifo_valid;
  assign pwr_end = (cnt == state_last(PWR));
`endif

  // Next state/counter; outputs are decoded from these so every field changes
  // on the edge that enters the state driving it
  always_comb begin
    st_n       = st;
    cnt_n      = cnt + 6'd1;
    kij_n      = kij;
    ocnt_n     = ocnt;
    pwr_rd_n   = 1'b0;
    pwr_wr_n   = 1'b0;
    pwr_widx_n = '0;
    case (st)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          st_n  = CRST;
          kij_n = '0;
        end
      end
      CRST, W2L0, WLOAD, WGAP, X2L0, EXEC, DRAIN: begin
        if (cnt == state_last(st)) begin
          st_n  = phase_next(st);
          cnt_n = '0;
        end
      end
      PWR: begin
        if (pwr_end) begin
          cnt_n  = '0;
          ocnt_n = '0;
          if (kij == 4'(LEN_KIJ - 1)) begin
            st_n = ACC;
          end else begin
            st_n  = CRST;
            kij_n = kij + 4'd1;
          end
        end
      end
      ACC: begin
        if (cnt == state_last(ACC)) begin
          cnt_n = '0;
          if (ocnt == 4'(LEN_ONIJ - 1)) st_n = DONE;
          else                          ocnt_n = ocnt + 4'd1;
        end
      end
      DONE: begin
        st_n  = IDLE;
        cnt_n = '0;
      end
      default: begin
        st_n  = IDLE;
        cnt_n = '0;
      end
    endcase

    if (st_n == PWR) begin
`ifdef CORE_CTRL_OFIFO_HS_EN
      pwr_wr_n   = (st == PWR) && inst[OFIFO_RD];
      pwr_widx_n = cnt - 6'd1;
      pwr_rd_n   = ofifo_valid && ((st != PWR) || (cnt < 6'(LEN_NIJ)));
      cnt_n      = ((st == PWR) ? cnt : 6'd0) + {5'd0, pwr_rd_n};
`else
      pwr_rd_n   = cnt_n < 6'(LEN_NIJ);
      pwr_wr_n   = cnt_n != 6'd0;
      pwr_widx_n = cnt_n - 6'd1;
`endif
    end
  end

  // Decode the upcoming cycle's inst word and side-band strobes
  always_comb begin
    inst_n = INST_IDLE;
    crst_n = 1'b0;
    ov_n   = 1'b0;
    ag_adv = 1'b0;
    ag_clr = (st_n != ACC);
    case (st_n)
      IDLE, CRST: crst_n = 1'b1;
      W2L0: begin
        inst_n[CEN_XMEM] = 1'b0;
        inst_n[A_XMEM_LSB +: ADDR_W] = WBASE + 11'(kij_n) * 11'(COL) + 11'(cnt_n);
        inst_n[L0_WR] = 1'b1;
      end
      WLOAD: begin
        inst_n[L0_RD] = 1'b1;
        inst_n[LOAD]  = 1'b1;
      end
      X2L0: begin
        inst_n[CEN_XMEM] = 1'b0;
        inst_n[A_XMEM_LSB +: ADDR_W] = 11'(cnt_n);
        inst_n[L0_WR] = 1'b1;
      end
      EXEC: begin
        inst_n[L0_RD]   = 1'b1;
        inst_n[EXECUTE] = 1'b1;
      end
      PWR: begin
        inst_n[OFIFO_RD] = pwr_rd_n;
        if (pwr_wr_n) begin
          inst_n[CEN_PMEM] = 1'b0;
          inst_n[WEN_PMEM] = 1'b0;
          inst_n[A_PMEM_LSB +: ADDR_W] = 11'(kij_n) * 11'(LEN_NIJ) + 11'(pwr_widx_n);
        end
      end
      ACC: begin
        if (cnt_n == 6'd0) crst_n = 1'b1;
        if (cnt_n >= 6'd1 && cnt_n <= 6'(LEN_KIJ)) begin
          inst_n[CEN_PMEM] = 1'b0;
          inst_n[A_PMEM_LSB +: ADDR_W] = ag_addr;
          ag_adv = 1'b1;
        end
        if (cnt_n >= 6'd2 && cnt_n <= 6'(LEN_KIJ + 1)) inst_n[ACC_B] = 1'b1;
        if (cnt_n == 6'(LEN_KIJ + 2)) ov_n = 1'b1;
      end
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      st         <= IDLE;
      cnt        <= '0;
      kij        <= '0;
      ocnt       <= '0;
      inst       <= INST_IDLE;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      kij        <= kij_n;
      ocnt       <= ocnt_n;
      inst       <= inst_n;
      core_reset <= crst_n;
      busy       <= (st_n != IDLE);
      done       <= (st_n == DONE);
      out_valid  <= ov_n;
    end
  end

  assign kij_idx = kij;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: table-driven checks of the core_ctrl inst sequence plus
// hand-written reset/abort/re-start sequences.
module tb_core_ctrl;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        core_reset, busy, done, out_valid;
  logic [3:0]  kij_idx;

  int checks = 0;
  int errors = 0;
  int done_cyc;

  core_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .core_reset  (core_reset),
    .busy        (busy),
    .done        (done),
    .out_valid   (out_valid),
    .kij_idx     (kij_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [33:0] inst;
    logic        crst, bsy, ov, dn;
    logic [3:0]  kij;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [33:0] xrd(input int a);
    logic [33:0] w;
    w = IDLE_W;
    w[19] = 1'b0;
    w[17:7] = 11'(a);
    w[2] = 1'b1;
    return w;
  endfunction

  function automatic logic [33:0] prd(input int a, input bit acc);
    logic [33:0] w;
    w = IDLE_W;
    w[32] = 1'b0;
    w[30:20] = 11'(a);
    w[33] = acc;
    return w;
  endfunction

  // a < 0: no pmem write this cycle
  function automatic logic [33:0] pwr(input bit rd, input int a);
    logic [33:0] w;
    w = IDLE_W;
    w[6] = rd;
    if (a >= 0) begin
      w[32] = 1'b0;
      w[31] = 1'b0;
      w[30:20] = 11'(a);
    end
    return w;
  endfunction

  function automatic void add(input int c, input logic [33:0] w, input logic cr,
                              input logic b, input logic ov, input logic dn, input int k);
    vec_t v;
    v.cyc = c; v.inst = w; v.crst = cr; v.bsy = b; v.ov = ov; v.dn = dn; v.kij = 4'(k);
    tab.push_back(v);
  endfunction

  // One start-to-done run; cycle c = c-th rising edge counting the one that samples start
  task automatic run_seq(input int pulse_cyc, input int abort_cyc);
    int  rd_cnt = 0, acc_r = 0, ov_cnt = 0, ti = 0, pair_err = 0, wexp = 0, first_rd = 0;
    int  o, k, ea;
    bit  prev_rd = 1'b0, wr_now;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 2500; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (abort_cyc != 0 && c == abort_cyc + 1) begin
        chk("abort_inst", inst, IDLE_W);
        chk("abort_ctrl", {core_reset, busy, kij_idx}, {1'b1, 1'b0, 4'd0});
        reset = 1'b1;
        return;
      end
      if (ti < tab.size() && tab[ti].cyc == c) begin
        chk($sformatf("inst@%0d", c), inst, tab[ti].inst);
        chk($sformatf("ctrl@%0d", c), {core_reset, busy, out_valid, done, kij_idx},
            {tab[ti].crst, tab[ti].bsy, tab[ti].ov, tab[ti].dn, tab[ti].kij});
        ti++;
      end
      wr_now = !inst[32] && !inst[31];
      if (wr_now != prev_rd) pair_err++;
      if (wr_now) begin
        if (inst[30:20] != 11'(wexp)) pair_err++;
        wexp++;
`ifdef CORE_CTRL_OFIFO_HS_EN
        if (wexp % 36 == 0) chk("pwr_len", c - first_rd + 1, 72);
`endif
      end
      if (!inst[32] && inst[31]) begin
        o = acc_r / 9;
        k = acc_r % 9;
        ea = k * 36 + (o / 4 + k / 3) * 6 + (o % 4) + (k % 3);
        chk($sformatf("acc_addr o%0d k%0d", o, k), inst[30:20], ea);
        acc_r++;
      end
      if (inst[6]) begin
        if (rd_cnt % 36 == 0) first_rd = c;
        rd_cnt++;
`ifdef CORE_CTRL_OFIFO_HS_EN
        if (!ofifo_valid) pair_err++;
`endif
      end
      prev_rd = inst[6];
      if (out_valid) ov_cnt++;
      if (done && done_cyc < 0) done_cyc = c;
      start = (c == pulse_cyc);
      if (c == abort_cyc) reset = 1'b0;
      ofifo_valid = ~ofifo_valid;
      if (done_cyc > 0 && c == done_cyc + 1) break;
    end
    start = 1'b0;
    chk("done_seen", done_cyc > 0, 1);
`ifndef CORE_CTRL_OFIFO_HS_EN
    chk("done_cycle", done_cyc, 1624);
`endif
    chk("out_valid_count", ov_cnt, 16);
    chk("ofifo_rd_count", rd_cnt, 324);
    chk("pmem_wr_count", wexp, 324);
    chk("acc_rd_count", acc_r, 144);
    chk("rd_wr_pairing", pair_err, 0);
  endtask

  initial begin
`ifndef CORE_CTRL_OFIFO_HS_EN
    add(1,    IDLE_W,                 1, 1, 0, 0, 0);
    add(2,    IDLE_W,                 1, 1, 0, 0, 0);
    add(3,    xrd(1024),              0, 1, 0, 0, 0);
    add(10,   xrd(1031),              0, 1, 0, 0, 0);
    add(11,   IDLE_W | 34'h9,         0, 1, 0, 0, 0);
    add(18,   IDLE_W | 34'h9,         0, 1, 0, 0, 0);
    add(19,   IDLE_W,                 0, 1, 0, 0, 0);
    add(35,   xrd(0),                 0, 1, 0, 0, 0);
    add(70,   xrd(35),                0, 1, 0, 0, 0);
    add(71,   IDLE_W | 34'hA,         0, 1, 0, 0, 0);
    add(106,  IDLE_W | 34'hA,         0, 1, 0, 0, 0);
    add(107,  IDLE_W,                 0, 1, 0, 0, 0);
    add(123,  pwr(1, -1),             0, 1, 0, 0, 0);
    add(124,  pwr(1, 0),              0, 1, 0, 0, 0);
    add(158,  pwr(1, 34),             0, 1, 0, 0, 0);
    add(159,  pwr(0, 35),             0, 1, 0, 0, 0);
    add(160,  IDLE_W,                 1, 1, 0, 0, 1);
    add(600,  pwr(1, -1),             0, 1, 0, 0, 3);
    add(601,  pwr(1, 108),            0, 1, 0, 0, 3);
    add(636,  pwr(0, 143),            0, 1, 0, 0, 3);
    add(1275, xrd(1088),              0, 1, 0, 0, 8);
    add(1432, IDLE_W,                 1, 1, 0, 0, 8);
    add(1433, prd(0, 0),              0, 1, 0, 0, 8);
    add(1434, prd(37, 1),             0, 1, 0, 0, 8);
    add(1441, prd(302, 1),            0, 1, 0, 0, 8);
    add(1442, IDLE_W | (34'd1 << 33), 0, 1, 0, 0, 8);
    add(1443, IDLE_W,                 0, 1, 1, 0, 8);
    add(1497, prd(158, 1),            0, 1, 0, 0, 8);
    add(1621, prd(323, 1),            0, 1, 0, 0, 8);
    add(1624, IDLE_W,                 0, 1, 0, 1, 8);
    add(1625, IDLE_W,                 1, 0, 0, 0, 8);
`endif

    // Reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inst", inst, IDLE_W);
    chk("rst_ctrl", {core_reset, busy, done, out_valid, kij_idx}, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_inst", inst, IDLE_W);
    chk("post_rst_ctrl", {core_reset, busy}, {1'b1, 1'b0});

    // start together with reset: reset wins
    start = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("start_in_reset_busy", busy, 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("start_in_reset_idle", {busy, inst}, {1'b0, IDLE_W});

    run_seq(0, 0);      // plain run
    run_seq(400, 0);    // start re-pulsed during EXEC of kij2
    run_seq(0, 770);    // reset during PWR of kij4
    run_seq(0, 0);      // full run after the abort

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
